// File: rtl/io_interval_timer.sv
// io_interval_timer: 32-bit down-counting interval timer with prescaler and level interrupt.
// Optional PWM compare register and PwmOut port are built when KTIMER_PWM_EN is defined.
`timescale 1ns/1ps
module io_interval_timer #(
    parameter int unsigned PRESCALE_W   = 8,
    parameter logic [31:0] RESET_RELOAD = 32'hFFFF_FFFF
) (
    input  logic        Sys_Clock,
    input  logic        Sys_Reset,
    input  logic        Sys_BlockSelect,
    input  logic [3:0]  Sys_RegAddress,
    input  logic [31:0] Sys_WrData,
    input  logic        Sys_WrEn,
    input  logic        Sys_RdEn,
    output logic [31:0] Sys_RdData,
    output logic        IntReq,
`ifdef KTIMER_PWM_EN
    output logic        PwmOut,
`endif
    input  logic        IntAck
);

    localparam logic [3:0] AddrCtrl   = 4'd0;
    localparam logic [3:0] AddrReload = 4'd1;
    localparam logic [3:0] AddrCount  = 4'd2;
    localparam logic [3:0] AddrStatus = 4'd3;
`ifdef KTIMER_PWM_EN
    localparam logic [3:0] AddrCmp    = 4'd5;
`endif

    localparam logic [PRESCALE_W-1:0] PresOne = PRESCALE_W'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  inten_q, inten_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [31:0]           reload_q, reload_d;
    logic [31:0]           count_q, count_d;
    logic                  exp_q, exp_d;
    logic                  int_req_q, int_req_d;
    logic [31:0]           rd_data_q, rd_data_d;
`ifdef KTIMER_PWM_EN
    logic [31:0]           cmp_q, cmp_d;
    logic                  pwm_q, pwm_d;
`endif

    logic                  wr_en;
    logic                  rd_en;
    logic                  tick;
    logic                  expire;
    logic                  w1c;
    logic [7:0]            prescale_rd;
    logic [31:0]           rd_mux;

    assign wr_en       = Sys_BlockSelect & Sys_WrEn;
    assign rd_en       = Sys_BlockSelect & Sys_RdEn;
    assign prescale_rd = 8'(prescale_q);

    always_comb begin
        rd_mux = '0;
        case (Sys_RegAddress)
            AddrCtrl:   rd_mux = {16'h0000, prescale_rd, 5'b00000, inten_q, auto_q, en_q};
            AddrReload: rd_mux = reload_q;
            AddrCount:  rd_mux = count_q;
            AddrStatus: rd_mux = {31'd0, exp_q};
`ifdef KTIMER_PWM_EN
            AddrCmp:    rd_mux = cmp_q;
`endif
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        auto_d     = auto_q;
        inten_d    = inten_q;
        prescale_d = prescale_q;
        presc_d    = presc_q;
        reload_d   = reload_q;
        count_d    = count_q;
        exp_d      = exp_q;
        tick       = 1'b0;
        expire     = 1'b0;
        w1c        = 1'b0;
`ifdef KTIMER_PWM_EN
        cmp_d      = cmp_q;
`endif

        // Prescaler only advances while running; >= guards a PRESCALE lowered mid-count.
        if (state_q == StRun) begin
            if (presc_q >= prescale_q) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PresOne;
            end
        end

        if (tick) begin
            if (count_q == 32'd1) begin
                count_d = '0;
                expire  = 1'b1;
                if (!auto_q) begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end else if (count_q == '0) begin
                // Reload tick; a zero reload value expires on every tick.
                if (auto_q) begin
                    count_d = reload_q;
                    expire  = (reload_q == '0);
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (wr_en) begin
            case (Sys_RegAddress)
                AddrCtrl: begin
                    en_d       = Sys_WrData[0];
                    auto_d     = Sys_WrData[1];
                    inten_d    = Sys_WrData[2];
                    prescale_d = Sys_WrData[8 +: PRESCALE_W];
                    if (Sys_WrData[0]) begin
                        state_d = StRun;
                        if ((state_q == StIdle || expire) && count_d == '0) begin
                            count_d = reload_q;
                        end
                    end else begin
                        state_d = StIdle;
                        count_d = count_q;
                        presc_d = presc_q;
                    end
                end
                AddrReload: reload_d = Sys_WrData;
                AddrCount: begin
                    count_d = Sys_WrData;
                    presc_d = '0;
                end
                AddrStatus: w1c = Sys_WrData[0];
`ifdef KTIMER_PWM_EN
                AddrCmp:    cmp_d = Sys_WrData;
`endif
                default: ;
            endcase
        end

        // Set has priority over both clear sources.
        if (w1c || (IntAck && int_req_q)) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end

        int_req_d = exp_q & inten_q;
        rd_data_d = rd_en ? rd_mux : rd_data_q;
`ifdef KTIMER_PWM_EN
        pwm_d     = (state_q == StRun) && (count_q < cmp_q);
`endif
    end

    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            inten_q    <= 1'b0;
            prescale_q <= '0;
            presc_q    <= '0;
            reload_q   <= RESET_RELOAD;
            count_q    <= '0;
            exp_q      <= 1'b0;
            int_req_q  <= 1'b0;
            rd_data_q  <= '0;
`ifdef KTIMER_PWM_EN
            cmp_q      <= '0;
            pwm_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            inten_q    <= inten_d;
            prescale_q <= prescale_d;
            presc_q    <= presc_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            int_req_q  <= int_req_d;
            rd_data_q  <= rd_data_d;
`ifdef KTIMER_PWM_EN
            cmp_q      <= cmp_d;
            pwm_q      <= pwm_d;
`endif
        end
    end

    assign Sys_RdData = rd_data_q;
    assign IntReq     = int_req_q;
`ifdef KTIMER_PWM_EN
    assign PwmOut     = pwm_q;
`endif

endmodule

// File: tb/tb_io_interval_timer.sv
// Scoreboard bench for io_interval_timer: reads push expected data, a monitor pops and compares.
`timescale 1ns/1ps
module tb_io_interval_timer;

    logic        Sys_Clock = 1'b0;
    logic        Sys_Reset;
    logic        Sys_BlockSelect;
    logic [3:0]  Sys_RegAddress;
    logic [31:0] Sys_WrData;
    logic        Sys_WrEn;
    logic        Sys_RdEn;
    logic [31:0] Sys_RdData;
    logic        IntReq;
    logic        IntAck;
`ifdef KTIMER_PWM_EN
    logic        PwmOut;
`endif

    io_interval_timer dut (
        .Sys_Clock       (Sys_Clock),
        .Sys_Reset       (Sys_Reset),
        .Sys_BlockSelect (Sys_BlockSelect),
        .Sys_RegAddress  (Sys_RegAddress),
        .Sys_WrData      (Sys_WrData),
        .Sys_WrEn        (Sys_WrEn),
        .Sys_RdEn        (Sys_RdEn),
        .Sys_RdData      (Sys_RdData),
        .IntReq          (IntReq),
`ifdef KTIMER_PWM_EN
        .PwmOut          (PwmOut),
`endif
        .IntAck          (IntAck)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic rd_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Read data is due one cycle after a sampled read strobe.
    always @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) rd_vld <= 1'b0;
        else            rd_vld <= Sys_BlockSelect & Sys_RdEn;
    end

    always @(negedge Sys_Clock) begin
        if (rd_vld) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got read data %h, expected none", Sys_RdData);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk(e.name, Sys_RdData, e.exp);
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        Sys_BlockSelect = 1'b1;
        Sys_RegAddress  = a;
        Sys_WrData      = d;
        Sys_WrEn        = 1'b1;
        @(negedge Sys_Clock);
        Sys_BlockSelect = 1'b0;
        Sys_WrEn        = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
        Sys_BlockSelect = 1'b1;
        Sys_RegAddress  = a;
        Sys_RdEn        = 1'b1;
        @(negedge Sys_Clock);
        Sys_BlockSelect = 1'b0;
        Sys_RdEn        = 1'b0;
    endtask

    task automatic pulse_ack();
        IntAck = 1'b1;
        @(negedge Sys_Clock);
        IntAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] auto_seq [9];
`ifdef KTIMER_PWM_EN
    int highs;
`endif

    initial begin
        auto_seq = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd3};
        Sys_Reset = 1'b0;
        Sys_BlockSelect = 1'b0;
        Sys_RegAddress = '0;
        Sys_WrData = '0;
        Sys_WrEn = 1'b0;
        Sys_RdEn = 1'b0;
        IntAck = 1'b0;
        repeat (3) @(negedge Sys_Clock);
        Sys_Reset = 1'b1;

        // Reset values
        chk("rst_intreq", {31'd0, IntReq}, 32'd0);
        rd(4'd0, 32'h0, "rst_ctrl");
        rd(4'd1, 32'hFFFF_FFFF, "rst_reload");
        rd(4'd2, 32'h0, "rst_count");
        rd(4'd3, 32'h0, "rst_status");
        rd(4'd4, 32'h0, "rst_resv4");
        rd(4'd5, 32'h0, "rst_reg5");

        // One-shot: RELOAD=5, EN|INTEN, PRESCALE=0
        wr(4'd1, 32'd5);
        wr(4'd0, 32'h5);
        repeat (4) @(negedge Sys_Clock);
        chk("os_irq_early", {31'd0, IntReq}, 32'd0);
        rd(4'd3, 32'h0, "os_exp_before");
        chk("os_irq_lag", {31'd0, IntReq}, 32'd0);
        rd(4'd3, 32'h1, "os_exp_set");
        chk("os_irq_high", {31'd0, IntReq}, 32'd1);
        rd(4'd0, 32'h4, "os_ctrl_en_clr");
        rd(4'd2, 32'h0, "os_count_zero");

        // Interrupt acknowledge handshake
        pulse_ack();
        @(negedge Sys_Clock);
        chk("ack_irq_drop", {31'd0, IntReq}, 32'd0);
        rd(4'd3, 32'h0, "ack_exp_clr");
        pulse_ack();
        rd(4'd3, 32'h0, "ack_idle_status");
        chk("ack_idle_irq", {31'd0, IntReq}, 32'd0);

        // Auto-reload: RELOAD=3, PRESCALE=1
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h107);
        for (int i = 0; i < 9; i++) begin
            rd(4'd2, auto_seq[i], $sformatf("auto_count%0d", i));
        end
        wr(4'd3, 32'h1);
        chk("w1c_irq_hold", {31'd0, IntReq}, 32'd1);
        rd(4'd3, 32'h0, "w1c_exp_clr");
        chk("w1c_irq_drop", {31'd0, IntReq}, 32'd0);
        wr(4'd0, 32'h0);

        // COUNT write coincident with a tick
        wr(4'd2, 32'd100);
        wr(4'd0, 32'h1);
        wr(4'd2, 32'd10);
        rd(4'd2, 32'd10, "coll_count_wr");
        wr(4'd0, 32'h0);

        // W1C coincident with expiry, INTEN=0
        wr(4'd3, 32'h1);
        wr(4'd2, 32'd3);
        wr(4'd0, 32'h1);
        repeat (2) @(negedge Sys_Clock);
        wr(4'd3, 32'h1);
        rd(4'd3, 32'h1, "coll_set_wins");
        chk("coll_irq_masked", {31'd0, IntReq}, 32'd0);
        pulse_ack();
        rd(4'd3, 32'h1, "ack_ignored");
        wr(4'd3, 32'h1);
        rd(4'd3, 32'h0, "coll_clr");

        // Reset mid-RUN
        wr(4'd1, 32'd2);
        wr(4'd0, 32'h7);
        repeat (4) @(negedge Sys_Clock);
        chk("run_irq_high", {31'd0, IntReq}, 32'd1);
        rd(4'd1, 32'd2, "run_reload");
        #2 Sys_Reset = 1'b0;
        #1;
        chk("arst_irq", {31'd0, IntReq}, 32'd0);
        chk("arst_rddata", Sys_RdData, 32'd0);
        @(negedge Sys_Clock);
        Sys_Reset = 1'b1;
        rd(4'd0, 32'h0, "arst_ctrl");
        rd(4'd1, 32'hFFFF_FFFF, "arst_reload");
        rd(4'd2, 32'h0, "arst_count");
        rd(4'd3, 32'h0, "arst_status");
        repeat (5) @(negedge Sys_Clock);
        rd(4'd2, 32'h0, "idle_frozen");

`ifdef KTIMER_PWM_EN
        chk("pwm_rst", {31'd0, PwmOut}, 32'd0);
        wr(4'd5, 32'd4);
        wr(4'd1, 32'd9);
        wr(4'd0, 32'h3);
        repeat (2) @(negedge Sys_Clock);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (PwmOut) highs++;
            @(negedge Sys_Clock);
        end
        chk("pwm_duty", 32'(highs), 32'd8);
        wr(4'd5, 32'd0);
        repeat (2) @(negedge Sys_Clock);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (PwmOut) highs++;
            @(negedge Sys_Clock);
        end
        chk("pwm_cmp0", 32'(highs), 32'd0);
`endif

        repeat (2) @(negedge Sys_Clock);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
